change_dispenser: RTL

//  Downstream stage of the vending FSM: consumes give_1/2/4 change pulses, converts the amount into
//  1- and 2-ruble coin ejections and drives the coin hopper one coin at a time with a sensor handshake.

---
 rtl/change_pkg.sv | 36 +++
 rtl/eject_timer.sv | 37 +++
 rtl/change_dispenser.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/change_pkg.sv
// ---------------------------------------------------------------------------
// change_pkg
// Types and constants shared by the change dispenser and the vending FSM
// that drives it.
//   dstate_t       : dispenser FSM state encoding
//   COIN*_VAL      : ruble value carried by each give_* request line
//   change_amount  : sums the three request pulses into a 0..7 ruble amount
// ---------------------------------------------------------------------------
package change_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT1,
        EJECT2,
        WAIT,
        FAULT
    } dstate_t;

    localparam int COIN1_VAL = 1;
    localparam int COIN2_VAL = 2;
    localparam int COIN4_VAL = 4;

    // Simultaneous request pulses are summed, never prioritised.
    function automatic logic [2:0] change_amount(input logic g1,
                                                 input logic g2,
                                                 input logic g4);
        logic [2:0] sum;
        sum = 3'd0;
        if (g1) sum = sum + 3'(COIN1_VAL);
        if (g2) sum = sum + 3'(COIN2_VAL);
        if (g4) sum = sum + 3'(COIN4_VAL);
        return sum;
    endfunction

endpackage

// File: rtl/eject_timer.sv
// ---------------------------------------------------------------------------
// eject_timer
// Counts cycles spent waiting for the hopper sensor after a coin eject.
//   CLK      in   clock
//   reset_n  in   synchronous reset, active low
//   clear    in   restart the count at 0 (asserted during the eject cycle)
//   enable   in   count while waiting for coin_sensed
//   expired  out  count has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module eject_timer #(
    parameter int TIMEOUT = 200
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] count;

    assign expired = (count == W'(TIMEOUT - 1));

    // Holds at TIMEOUT-1 so the count can never wrap if enable lingers.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
// Converts give_1/2/4 change requests into a sequence of 1- and 2-ruble coin
// ejections, one coin at a time, handshaking each with the hopper exit sensor.
// Tracks hopper stock, halts on an empty hopper or a jam, reports busy.
//
// Ports
//   CLK, reset_n                 clock, synchronous active-low reset
//   give_1/2/4_*_back            change request pulses (summed when coincident)
//   coin_sensed                  hopper sensor, one pulse per dropped coin
//   refill                       reload stock; also leaves FAULT
//   eject_1, eject_2             one-cycle coin drop commands
//   busy                         a dispense is in progress
//   fault                        sticky fault, hopper halted until refill
//   req_drop                     a request arrived while not IDLE and was lost
//   stock_1, stock_2             coins left in the hopper
//   paid_total                   (only with CHANGE_AUDIT_EN) rubles paid out,
//                                wraps modulo 2^16, survives refill
//
// Build option: define CHANGE_AUDIT_EN to add the paid_total audit counter.
// ---------------------------------------------------------------------------
module change_dispenser
    import change_pkg::*;
#(
    parameter int CNT_W       = 5,
    parameter int STOCK1_INIT = 15,
    parameter int STOCK2_INIT = 15,
    parameter int TIMEOUT     = 200
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             give_1_ruble_back,
    input  logic             give_2_rubles_back,
    input  logic             give_4_rubles_back,
    input  logic             coin_sensed,
    input  logic             refill,
    output logic             eject_1,
    output logic             eject_2,
    output logic             busy,
    output logic             fault,
    output logic             req_drop,
    output logic [CNT_W-1:0] stock_1,
    output logic [CNT_W-1:0] stock_2
`ifdef CHANGE_AUDIT_EN
    ,
    output logic [15:0]      paid_total
`endif
);

    dstate_t    state;
    dstate_t    state_next;
    logic [2:0] amount;
    logic [2:0] remaining;
    logic       coin_is_2;      // value of the coin currently in flight
    logic       timer_expired;

    assign amount = change_amount(give_1_ruble_back, give_2_rubles_back,
                                  give_4_rubles_back);

    // Sensor glitches must not wrap a stock counter below zero.
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    eject_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_eject_timer (
        .CLK     (CLK),
        .reset_n (reset_n),
        .clear   (state == EJECT1 || state == EJECT2),
        .enable  (state == WAIT),
        .expired (timer_expired)
    );

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and process order cannot change behaviour.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: state_next gets its default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (amount != 3'd0) state_next = SELECT;
            end
            SELECT: begin
                // Largest coin first; an empty 2-ruble tube falls back to 1s.
                if (remaining >= 3'd2 && stock_2 != '0) begin
                    state_next = EJECT2;
                end else if (remaining >= 3'd1 && stock_1 != '0) begin
                    state_next = EJECT1;
                end else if (remaining == 3'd0) begin
                    state_next = IDLE;
                end else begin
                    state_next = FAULT;
                end
            end
            EJECT1, EJECT2: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (coin_sensed) begin
                    state_next = SELECT;
                end else if (timer_expired) begin
                    state_next = FAULT;
                end
            end
            FAULT: begin
                if (refill) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore outputs: each eject state lasts exactly one cycle.
    assign eject_1 = (state == EJECT1);
    assign eject_2 = (state == EJECT2);
    assign busy    = (state != IDLE);
    assign fault   = (state == FAULT);

    // -----------------------------------------------------------------------
    // Datapath: remaining amount, stock counters, drop flag
    // -----------------------------------------------------------------------
    // NOTE: every register here is reset, including the stock counters, so a
    // reset mid-dispense restores a known hopper model with nothing in flight.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            remaining <= 3'd0;
            coin_is_2 <= 1'b0;
            req_drop  <= 1'b0;
            stock_1   <= CNT_W'(STOCK1_INIT);
            stock_2   <= CNT_W'(STOCK2_INIT);
        end else begin
            // Requests are only accepted in IDLE; anything else is flagged.
            req_drop <= (state != IDLE) && (amount != 3'd0);

            unique case (state)
                IDLE: begin
                    if (amount != 3'd0) remaining <= amount;
                    if (refill) begin
                        stock_1 <= CNT_W'(STOCK1_INIT);
                        stock_2 <= CNT_W'(STOCK2_INIT);
                    end
                end
                EJECT1: coin_is_2 <= 1'b0;
                EJECT2: coin_is_2 <= 1'b1;
                WAIT: begin
                    if (coin_sensed) begin
                        if (coin_is_2) begin
                            stock_2   <= sat_dec(stock_2);
                            remaining <= (remaining >= 3'(COIN2_VAL))
                                         ? remaining - 3'(COIN2_VAL) : 3'd0;
                        end else begin
                            stock_1   <= sat_dec(stock_1);
                            remaining <= (remaining >= 3'(COIN1_VAL))
                                         ? remaining - 3'(COIN1_VAL) : 3'd0;
                        end
                    end
                end
                FAULT: begin
                    // remaining is held while faulted; refill abandons it.
                    if (refill) begin
                        remaining <= 3'd0;
                        stock_1   <= CNT_W'(STOCK1_INIT);
                        stock_2   <= CNT_W'(STOCK2_INIT);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CHANGE_AUDIT_EN
    // Audit of rubles physically paid out; refill does not clear it.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            paid_total <= 16'd0;
        end else if (state == WAIT && coin_sensed) begin
            paid_total <= paid_total + (coin_is_2 ? 16'(COIN2_VAL)
                                                  : 16'(COIN1_VAL));
        end
    end
`endif

endmodule
